control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-high, with ports named clock and clear.
REQ-002 clock  input  1  rising-edge system clock shared with the datapath.
REQ-003 clear  input  1  asynchronous active-high reset.
REQ-004 IR  input  32  instruction register contents; opcode field IR[31:27].
REQ-005 conOut  input  1  branch condition from the CON flip-flop.
REQ-006 PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPort_Out  output  1 each  bus-source selects.
REQ-007 enablePC, enableIR, enableMAR, enableMDR, enableY, enableZ, enableHI, enableLO, enableOutPort  output  1 each  register load enables.
REQ-008 IncPC, Read, enableRAM, conIn  output  1 each  PC increment, memory read, memory write, CON load.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  select-and-encode controls.
REQ-010 R_ins  output  16  direct register-file load enables; only bit 15 is ever driven, all other bits are tied to 0.
REQ-011 opcode  output  5  ALU operation code.
REQ-012 Run  output  1  high while executing; low in RESET and HALT.

Function
REQ-013 The FSM SHALL have the states RESET, T0..T7 and HALT; all outputs SHALL be Moore outputs decoded from state and IR.
REQ-014 Opcode map (IR[31:27]): ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jal 10100, jr 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011; any other code SHALL execute as nop.
REQ-015 Fetch SHALL be: T0 PCout, enableMAR, IncPC; T1 Read, enableMDR; T2 MDRout, enableIR.
REQ-016 After T2, the FSM SHALL go to T3, except for nop, which SHALL return to T0.
REQ-017 R-type ALU ops (add..shl): T3 Grb, Rout, enableY; T4 Grc, Rout, enableZ; T5 Zlowout, Gra, Rin.
REQ-018 Immediate ops (addi, andi, ori): same sequence as R-type, with Cout replacing Grc/Rout in T4.
REQ-019 mul/div: T3 Gra, Rout, enableY; T4 Grb, Rout, enableZ; T5 Zlowout, enableLO; T6 Zhighout, enableHI.
REQ-020 neg/not: T3 Grb, Rout, enableZ; T4 Zlowout, Gra, Rin.
REQ-021 ld: T3 Grb, BAout, enableY; T4 Cout, enableZ; T5 Zlowout, enableMAR; T6 Read, enableMDR; T7 MDRout, Gra, Rin.
REQ-022 ldi: T3 and T4 as ld; T5 Zlowout, Gra, Rin.
REQ-023 st: T3..T5 as ld; T6 Gra, Rout, enableMDR with Read=0; T7 enableRAM.
REQ-024 br: T3 Gra, Rout, conIn; T4 PCout, enableY; T5 Cout, enableZ; T6 Zlowout, with enablePC asserted only if conOut=1.
REQ-025 jr: T3 Gra, Rout, enablePC.
REQ-026 jal: T3 PCout, R_ins[15]; T4 Gra, Rout, enablePC.
REQ-027 in: T3 InPort_Out, Gra, Rin. out: T3 Gra, Rout, enableOutPort. mfhi/mflo: T3 HIout/LOout, Gra, Rin.
REQ-028 halt SHALL enter HALT in T3; HALT SHALL be absorbing until clear, with all enables deasserted.
REQ-029 The last step of each instruction SHALL be followed by T0 on the next clock.
REQ-030 opcode SHALL equal 00011 (add) in the address/offset steps of ld, ldi, st and br; otherwise it SHALL equal IR[31:27].
REQ-031 At most one bus-source select (REQ-006 signals, or Rout) SHALL be high in any cycle.
REQ-032 Read and enableRAM SHALL never be high together.

Reset
REQ-033 While clear=1, the state SHALL be RESET and all outputs 0, including Run, independent of clock.
REQ-034 The first rising clock edge with clear=0 SHALL move the FSM from RESET to T0, and Run SHALL go to 1.
REQ-035 Assertion of clear in any state, mid-instruction included, SHALL return the FSM to RESET immediately, with no further memory write.

Verification
REQ-036 clear pulse, then IR=add R3,R4,R5 (0x19A28000) -> T0,T1,T2,T3,T4,T5,T0; T4 opcode=00011, Grc/Rout/enableZ high; T5 Rin high.
REQ-037 IR=ld R2,0x95 -> 8-cycle sequence; T6 Read=1, enableMDR=1; T7 MDRout/Rin; opcode=00011 in T4.
REQ-038 IR=brzr, with conOut=0 and then conOut=1 in T6 -> enablePC is 0 and then 1 respectively; the next state is T0 in both cases.
REQ-039 IR=jal R6 -> T3 R_ins=0x8000 with PCout; T4 enablePC, Gra, Rout.
REQ-040 IR=halt -> HALT after T3, Run=0, and all outputs stay 0 for 10 cycles; clear then restarts the sequence at T0.
REQ-041 clear asserted during T6 of st -> outputs 0 in the same cycle, enableRAM never asserted, and the FSM resumes at T0 after clear is released.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control sequencer for the RISC datapath: fetch, decode, execute.
// Ports: clock/clear, IR, conOut in; bus selects, load enables, opcode, Run out.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        conOut,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPort_Out,
  output logic        enablePC,
  output logic        enableIR,
  output logic        enableMAR,
  output logic        enableMDR,
  output logic        enableY,
  output logic        enableZ,
  output logic        enableHI,
  output logic        enableLO,
  output logic        enableOutPort,
  output logic        IncPC,
  output logic        Read,
  output logic        enableRAM,
  output logic        conIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [15:0] R_ins,
  output logic [4:0]  opcode,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t state_q, state_d;

  logic [4:0] op;
  logic       unused_ir;
  assign op = IR[31:27];
  assign unused_ir = ^IR[26:0];

  logic c_ld, c_ldi, c_st, c_rtype, c_imm, c_muldiv;
  logic c_negnot, c_br, c_jal, c_jr, c_in, c_out;
  logic c_mflo, c_mfhi, c_halt;

  assign c_ld     = (op == OP_LD);
  assign c_ldi    = (op == OP_LDI);
  assign c_st     = (op == OP_ST);
  assign c_rtype  = (op >= OP_ADD) && (op <= OP_SHL);
  assign c_imm    = (op >= OP_ADDI) && (op <= OP_ORI);
  assign c_muldiv = (op == OP_DIV) || (op == OP_MUL);
  assign c_negnot = (op == OP_NEG) || (op == OP_NOT);
  assign c_br     = (op == OP_BR);
  assign c_jal    = (op == OP_JAL);
  assign c_jr     = (op == OP_JR);
  assign c_in     = (op == OP_IN);
  assign c_out    = (op == OP_OUT);
  assign c_mflo   = (op == OP_MFLO);
  assign c_mfhi   = (op == OP_MFHI);
  assign c_halt   = (op == OP_HALT);

  // Index of the final T-step of the current instruction; 2 means
  // nothing beyond fetch (nop and unassigned codes).
  logic [2:0] last_step;
  always_comb begin
    last_step = 3'd2;
    unique case (1'b1)
      c_ld, c_st:                   last_step = 3'd7;
      c_ldi, c_rtype, c_imm:        last_step = 3'd5;
      c_muldiv, c_br:               last_step = 3'd6;
      c_negnot, c_jal:              last_step = 3'd4;
      c_jr, c_in, c_out,
      c_mflo, c_mfhi, c_halt:       last_step = 3'd3;
      default:                      last_step = 3'd2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = (last_step == 3'd2) ? S_T0 : S_T3;
      S_T3: begin
        if (c_halt)                 state_d = S_HALT;
        else if (last_step == 3'd3) state_d = S_T0;
        else                        state_d = S_T4;
      end
      S_T4:    state_d = (last_step == 3'd4) ? S_T0 : S_T5;
      S_T5:    state_d = (last_step == 3'd5) ? S_T0 : S_T6;
      S_T6:    state_d = (last_step == 3'd6) ? S_T0 : S_T7;
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  logic rins15;
  assign R_ins = {rins15, 15'b0};

  always_comb begin
    PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; InPort_Out = 1'b0;
    enablePC = 1'b0; enableIR = 1'b0; enableMAR = 1'b0;
    enableMDR = 1'b0; enableY = 1'b0; enableZ = 1'b0;
    enableHI = 1'b0; enableLO = 1'b0; enableOutPort = 1'b0;
    IncPC = 1'b0; Read = 1'b0; enableRAM = 1'b0; conIn = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; rins15 = 1'b0;
    Run = (state_q != S_RESET) && (state_q != S_HALT);
    opcode = Run ? op : 5'b0;
    unique case (state_q)
      S_T0: begin PCout = 1'b1; enableMAR = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; enableMDR = 1'b1; end
      S_T2: begin MDRout = 1'b1; enableIR = 1'b1; end
      S_T3: begin
        unique case (1'b1)
          c_ld, c_ldi, c_st: begin
            Grb = 1'b1; BAout = 1'b1; enableY = 1'b1; opcode = OP_ADD;
          end
          c_rtype, c_imm: begin Grb = 1'b1; Rout = 1'b1; enableY = 1'b1; end
          c_muldiv: begin Gra = 1'b1; Rout = 1'b1; enableY = 1'b1; end
          c_negnot: begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
          c_br:     begin Gra = 1'b1; Rout = 1'b1; conIn = 1'b1; end
          c_jr:     begin Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; end
          c_jal:    begin PCout = 1'b1; rins15 = 1'b1; end
          c_in:     begin InPort_Out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          c_out:    begin Gra = 1'b1; Rout = 1'b1; enableOutPort = 1'b1; end
          c_mflo:   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          c_mfhi:   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default:  ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          c_ld, c_ldi, c_st: begin
            Cout = 1'b1; enableZ = 1'b1; opcode = OP_ADD;
          end
          c_rtype:  begin Grc = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
          c_imm:    begin Cout = 1'b1; enableZ = 1'b1; end
          c_muldiv: begin Grb = 1'b1; Rout = 1'b1; enableZ = 1'b1; end
          c_negnot: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          c_br: begin PCout = 1'b1; enableY = 1'b1; opcode = OP_ADD; end
          c_jal:    begin Gra = 1'b1; Rout = 1'b1; enablePC = 1'b1; end
          default:  ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          c_ld, c_st: begin Zlowout = 1'b1; enableMAR = 1'b1; end
          c_ldi, c_rtype, c_imm: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          c_muldiv: begin Zlowout = 1'b1; enableLO = 1'b1; end
          c_br: begin Cout = 1'b1; enableZ = 1'b1; opcode = OP_ADD; end
          default:  ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          c_ld:     begin Read = 1'b1; enableMDR = 1'b1; end
          c_st:     begin Gra = 1'b1; Rout = 1'b1; enableMDR = 1'b1; end
          c_muldiv: begin Zhighout = 1'b1; enableHI = 1'b1; end
          c_br:     begin Zlowout = 1'b1; enablePC = conOut; end
          default:  ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          c_ld:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          c_st:    enableRAM = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a per-instruction step-list model.
// Compares every output every cycle, plus halt, clear and bus-exclusion checks.
module tb_control_unit;

  logic        clock, clear, conOut;
  logic [31:0] IR;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPort_Out;
  logic enablePC, enableIR, enableMAR, enableMDR, enableY, enableZ;
  logic enableHI, enableLO, enableOutPort;
  logic IncPC, Read, enableRAM, conIn;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [15:0] R_ins;
  logic [4:0]  opcode;
  logic        Run;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .conOut(conOut),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .Cout(Cout),
    .InPort_Out(InPort_Out), .enablePC(enablePC), .enableIR(enableIR),
    .enableMAR(enableMAR), .enableMDR(enableMDR), .enableY(enableY),
    .enableZ(enableZ), .enableHI(enableHI), .enableLO(enableLO),
    .enableOutPort(enableOutPort), .IncPC(IncPC), .Read(Read),
    .enableRAM(enableRAM), .conIn(conIn), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .R_ins(R_ins), .opcode(opcode), .Run(Run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [26:0] PCO  = 27'd1 << 0;
  localparam logic [26:0] MDRO = 27'd1 << 1;
  localparam logic [26:0] ZHO  = 27'd1 << 2;
  localparam logic [26:0] ZLO  = 27'd1 << 3;
  localparam logic [26:0] HIO  = 27'd1 << 4;
  localparam logic [26:0] LOO  = 27'd1 << 5;
  localparam logic [26:0] CO   = 27'd1 << 6;
  localparam logic [26:0] INO  = 27'd1 << 7;
  localparam logic [26:0] RO   = 27'd1 << 8;
  localparam logic [26:0] EPC  = 27'd1 << 9;
  localparam logic [26:0] EIR  = 27'd1 << 10;
  localparam logic [26:0] EMAR = 27'd1 << 11;
  localparam logic [26:0] EMDR = 27'd1 << 12;
  localparam logic [26:0] EY   = 27'd1 << 13;
  localparam logic [26:0] EZ   = 27'd1 << 14;
  localparam logic [26:0] EHI  = 27'd1 << 15;
  localparam logic [26:0] ELO  = 27'd1 << 16;
  localparam logic [26:0] EOUT = 27'd1 << 17;
  localparam logic [26:0] INC  = 27'd1 << 18;
  localparam logic [26:0] RD   = 27'd1 << 19;
  localparam logic [26:0] ERAM = 27'd1 << 20;
  localparam logic [26:0] CIN  = 27'd1 << 21;
  localparam logic [26:0] GRA  = 27'd1 << 22;
  localparam logic [26:0] GRB  = 27'd1 << 23;
  localparam logic [26:0] GRC  = 27'd1 << 24;
  localparam logic [26:0] RIN  = 27'd1 << 25;
  localparam logic [26:0] BAO  = 27'd1 << 26;
  localparam logic [4:0]  ADD  = 5'b00011;

  logic [26:0] ctl;
  logic [8:0]  bus;
  logic [48:0] obs;
  assign ctl = {BAout, Rin, Grc, Grb, Gra, conIn, enableRAM, Read, IncPC,
                enableOutPort, enableLO, enableHI, enableZ, enableY,
                enableMDR, enableMAR, enableIR, enablePC, Rout, InPort_Out,
                Cout, LOout, HIout, Zlowout, Zhighout, MDRout, PCout};
  assign bus = {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout,
                InPort_Out, Rout};
  assign obs = {Run, opcode, R_ins, ctl};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [26:0] m;
    logic        r15;
    logic [4:0]  op;
  } step_t;

  step_t exp_q[$];

  task automatic add_step(input logic [26:0] m, input logic r15,
                          input logic [4:0] op);
    step_t s;
    s.m = m; s.r15 = r15; s.op = op;
    exp_q.push_back(s);
  endtask

  // Each instruction is a fetch prefix followed by its listed micro-steps.
  task automatic build(input logic [31:0] ir, input logic con);
    logic [4:0] op;
    op = ir[31:27];
    exp_q.delete();
    add_step(PCO | EMAR | INC, 1'b0, op);
    add_step(RD | EMDR, 1'b0, op);
    add_step(MDRO | EIR, 1'b0, op);
    case (op)
      5'd0: begin
        add_step(GRB | BAO | EY, 1'b0, ADD);
        add_step(CO | EZ, 1'b0, ADD);
        add_step(ZLO | EMAR, 1'b0, op);
        add_step(RD | EMDR, 1'b0, op);
        add_step(MDRO | GRA | RIN, 1'b0, op);
      end
      5'd1: begin
        add_step(GRB | BAO | EY, 1'b0, ADD);
        add_step(CO | EZ, 1'b0, ADD);
        add_step(ZLO | GRA | RIN, 1'b0, op);
      end
      5'd2: begin
        add_step(GRB | BAO | EY, 1'b0, ADD);
        add_step(CO | EZ, 1'b0, ADD);
        add_step(ZLO | EMAR, 1'b0, op);
        add_step(GRA | RO | EMDR, 1'b0, op);
        add_step(ERAM, 1'b0, op);
      end
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
        add_step(GRB | RO | EY, 1'b0, op);
        add_step(GRC | RO | EZ, 1'b0, op);
        add_step(ZLO | GRA | RIN, 1'b0, op);
      end
      5'd12, 5'd13, 5'd14: begin
        add_step(GRB | RO | EY, 1'b0, op);
        add_step(CO | EZ, 1'b0, op);
        add_step(ZLO | GRA | RIN, 1'b0, op);
      end
      5'd15, 5'd16: begin
        add_step(GRA | RO | EY, 1'b0, op);
        add_step(GRB | RO | EZ, 1'b0, op);
        add_step(ZLO | ELO, 1'b0, op);
        add_step(ZHO | EHI, 1'b0, op);
      end
      5'd17, 5'd18: begin
        add_step(GRB | RO | EZ, 1'b0, op);
        add_step(ZLO | GRA | RIN, 1'b0, op);
      end
      5'd19: begin
        add_step(GRA | RO | CIN, 1'b0, op);
        add_step(PCO | EY, 1'b0, ADD);
        add_step(CO | EZ, 1'b0, ADD);
        add_step(ZLO | (con ? EPC : 27'd0), 1'b0, op);
      end
      5'd20: begin
        add_step(PCO, 1'b1, op);
        add_step(GRA | RO | EPC, 1'b0, op);
      end
      5'd21: add_step(GRA | RO | EPC, 1'b0, op);
      5'd22: add_step(INO | GRA | RIN, 1'b0, op);
      5'd23: add_step(GRA | RO | EOUT, 1'b0, op);
      5'd24: add_step(LOO | GRA | RIN, 1'b0, op);
      5'd25: add_step(HIO | GRA | RIN, 1'b0, op);
      5'd27: add_step(27'd0, 1'b0, op);
      default: ;
    endcase
  endtask

  logic watch = 1'b0;
  int   ram_seen = 0;
  always @(enableRAM) if (watch && enableRAM) ram_seen++;

  // Entered at a falling edge in T0; leaves at the falling edge of the
  // state after the final step (or of T0 after an aborting clear).
  task automatic run_instr(input logic [31:0] ir, input logic con,
                           input int abort_at);
    logic [63:0] e;
    build(ir, con);
    IR = ir;
    conOut = con;
    if (abort_at >= 0) begin
      watch = 1'b1;
      ram_seen = 0;
    end
    foreach (exp_q[i]) begin
      #1;
      e = {15'd0, 1'b1, exp_q[i].op,
           (exp_q[i].r15 ? 16'h8000 : 16'h0000), exp_q[i].m};
      chk($sformatf("op%0d_t%0d", ir[31:27], i), {15'd0, obs}, e);
      chk("onebus", 64'($countones(bus) <= 1), 64'd1);
      chk("rd_ram", 64'(Read & enableRAM), 64'd0);
      if (i == abort_at) begin
        #1 clear = 1'b1;
        #1 chk("clr_now", {15'd0, obs}, 64'd0);
        @(posedge clock);
        #1 chk("clr_hold", {15'd0, obs}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        watch = 1'b0;
        chk("no_ram", 64'(ram_seen), 64'd0);
        @(negedge clock);
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic halt_and_restart;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("halt_c%0d", i), {15'd0, obs}, 64'd0);
      @(negedge clock);
    end
    clear = 1'b1;
    #1 chk("halt_clr", {15'd0, obs}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] ir;
    int          ab;
    clear = 1'b1;
    IR = 32'h0;
    conOut = 1'b0;
    #3 chk("rst_async", {15'd0, obs}, 64'd0);
    @(posedge clock);
    #1 chk("rst_hold", {15'd0, obs}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);

    run_instr(32'h19A28000, 1'b0, -1);
    run_instr(32'h01000095, 1'b0, -1);
    run_instr(32'h98800000, 1'b0, -1);
    run_instr(32'h98800000, 1'b1, -1);
    run_instr(32'hA3000000, 1'b0, -1);
    run_instr(32'h11800010, 1'b0, 6);
    run_instr(32'h11800010, 1'b0, -1);
    run_instr(32'hD0000000, 1'b0, -1);
    run_instr(32'hD8000000, 1'b0, -1);
    halt_and_restart();
    run_instr(32'h19A28000, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      op = 5'($urandom_range(0, 31));
      ir = {op, 27'($urandom)};
      ab = -1;
      if (op == 5'd2 && $urandom_range(0, 2) == 0)
        ab = $urandom_range(0, 6);
      run_instr(ir, 1'($urandom_range(0, 1)), ab);
      if (op == 5'd27) halt_and_restart();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
